egress_reader: RTL and testbench
================================

# egress_reader

Drains the two destination FIFOs (D0, D1) at the egress of the interconnect and serializes their words onto a single output stream with a valid/ready handshake. It is the read-side counterpart to the probador's Main FIFO writer: it owns D0_rd/D1_rd, arbitrates between the two destinations and tags each word with its source. Per-destination word counters let benches check conservation of words through the interconnect.

## Interface
- BW, 6, word width; matches the interconnect data width.
- CNT_W, 5, width of each per-destination delivered-word counter.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- D0_empty  input  1  D0 FIFO empty flag.
- D1_empty  input  1  D1 FIFO empty flag.
- D0_data_out  input  BW  D0 FIFO read data; valid the cycle after D0_rd.
- D1_data_out  input  BW  D1 FIFO read data; valid the cycle after D1_rd.
- D0_rd  output  1  D0 FIFO read strobe, registered.
- D1_rd  output  1  D1 FIFO read strobe, registered.
- out_ready  input  1  downstream accepts a word this cycle.
- out_valid  output  1  out_data/out_src hold a word.
- out_data  output  BW  delivered word.
- out_src  output  1  0 = word came from D0, 1 = from D1.
- D0_count  output  CNT_W  words delivered from D0, wraps modulo 2^CNT_W.
- D1_count  output  CNT_W  words delivered from D1, wraps modulo 2^CNT_W.
- idle  output  1  high in IDLE state.

## Operation
- FSM states: IDLE, READ, CAPTURE, HOLD.
- IDLE: if D0_empty and D1_empty are both high, stay. Otherwise select a source (arbitration below), register it in sel, and go to READ.
- READ: assert the selected D*_rd for exactly this cycle, then go to CAPTURE. The other rd is 0.
- CAPTURE: latch the selected D*_data_out into out_data and sel into out_src, then go to HOLD.
- HOLD: out_valid=1. If out_ready=1, the transfer completes: increment the count for out_src, update last-served, and go to IDLE. Otherwise hold, with out_data and out_src stable.
- Arbitration with EGRESS_READER_RR_EN: if only one source is non-empty, pick it. If both are non-empty, pick the source not served last (last-served resets to D1, so D0 wins first).
- Empty flags are sampled only in IDLE. This block is the sole reader, so a sampled non-empty FIFO cannot go empty before READ.
- Counters: CNT_W-bit unsigned, increment by 1 per completed transfer, 2^CNT_W−1 wraps to 0, no overflow flag.
- Reset (any state): next cycle state=IDLE; D0_rd=D1_rd=0; out_valid=0; out_data=0; out_src=0; D0_count=D1_count=0; idle=1; last-served=D1. A word already popped in READ/CAPTURE/HOLD is discarded.

## Timing
- All outputs are registered. There is no combinational path from an input to D*_rd or out_valid.
- Latency: a non-empty flag seen in IDLE at edge n gives rd high in cycle n+1, capture at edge n+2, and out_valid high in cycle n+3.
- Minimum 4 cycles per word (IDLE, READ, CAPTURE, HOLD with out_ready=1). At most one word is in flight.
- Handshake: a transfer occurs on the rising edge where out_valid && out_ready. out_valid drops in the following cycle (IDLE).
- out_ready while out_valid=0 is ignored. out_ready may stay high permanently.
- The rd strobe is exactly 1 cycle wide and never asserted on an empty FIFO.

## Configuration
- EGRESS_READER_RR_EN defined: round-robin arbitration as above. Neither destination starves while the other stays non-empty.
- Undefined: fixed priority. D0 is selected whenever D0_empty=0; D1 only when D0_empty=1. The last-served register is not built.

## Test plan
- Reset: assert reset for 2 cycles mid-HOLD with out_data=6'h2A -> next cycle out_valid=0, out_data=0, counts=0, idle=1, no rd pulses.
- Single word: D0 holds 6'h15, D1 empty, out_ready=1 -> D0_rd pulses 1 cycle, out_valid for 1 cycle with out_data=6'h15 and out_src=0, D0_count=1, then idle=1.
- Backpressure: D1 holds 6'h3C, out_ready=0 for 5 cycles then 1 -> out_valid held 6 cycles, data stable at 6'h3C, only one D1_rd pulse, D1_count increments once.
- Arbitration with RR_EN: D0 holds {01,02,03}, D1 holds {11,12,13} -> output order 01,11,02,12,03,13 with out_src alternating 0,1.
- Arbitration without RR_EN, same stimulus -> output order 01,02,03,11,12,13.
- Counter wrap: CNT_W=5, deliver 33 words from D0 -> D0_count reads 1 and D1_count reads 0; every delivered word matches the FIFO contents in order.

Source files
------------

// File: rtl/egress_reader.sv
// Egress reader: drains destination FIFOs D0/D1 onto one valid/ready stream, tagging each word with its source.
// Optional feature: define EGRESS_READER_RR_EN for round-robin arbitration; otherwise D0 has fixed priority.
module egress_reader #(
    parameter int BW    = 6,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BW-1:0]    out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] D0_count,
    output logic [CNT_W-1:0] D1_count,
    output logic             idle
);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic               r_sel;
    logic               r_d0_rd;
    logic               r_d1_rd;
    logic               r_out_valid;
    logic [BW-1:0]      r_out_data;
    logic               r_out_src;
    logic [CNT_W-1:0]   r_d0_count;
    logic [CNT_W-1:0]   r_d1_count;
    logic               r_idle;
    logic               w_any;
    logic               w_pick;
    logic               w_xfer;

    assign w_any  = !D0_empty || !D1_empty;
    assign w_xfer = (r_state == HOLD) && out_ready;

`ifdef EGRESS_READER_RR_EN
    logic r_last;

    // When both destinations have data, serve the one not served last.
    always_comb begin
        w_pick = D0_empty;
        if (!D0_empty && !D1_empty)
            w_pick = ~r_last;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_xfer)
            r_last <= r_out_src;
    end
`else
    assign w_pick = D0_empty;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = READ;
            READ:    w_next = CAPTURE;
            CAPTURE: w_next = HOLD;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes and status are registered off the next-state decision so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel       <= 1'b0;
            r_d0_rd     <= 1'b0;
            r_d1_rd     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_d0_count  <= '0;
            r_d1_count  <= '0;
            r_idle      <= 1'b1;
        end else begin
            r_d0_rd <= (r_state == IDLE) && w_any && !w_pick;
            r_d1_rd <= (r_state == IDLE) && w_any &&  w_pick;
            r_idle  <= (w_next == IDLE);
            if ((r_state == IDLE) && w_any)
                r_sel <= w_pick;
            if (r_state == CAPTURE) begin
                r_out_data  <= r_sel ? D1_data_out : D0_data_out;
                r_out_src   <= r_sel;
                r_out_valid <= 1'b1;
            end
            if (w_xfer) begin
                r_out_valid <= 1'b0;
                if (r_out_src)
                    r_d1_count <= r_d1_count + CNT_ONE;
                else
                    r_d0_count <= r_d0_count + CNT_ONE;
            end
        end
    end

    assign D0_rd     = r_d0_rd;
    assign D1_rd     = r_d1_rd;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign D0_count  = r_d0_count;
    assign D1_count  = r_d1_count;
    assign idle      = r_idle;

endmodule

// File: tb/tb_egress_reader.sv
// Scoreboard bench for egress_reader: FIFO models feed D0/D1, expected words queue up at load time,
// and a monitor pops and compares on every accepted transfer.
module tb_egress_reader;

    localparam int BW    = 6;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             D0_empty, D1_empty;
    logic [BW-1:0]    D0_data_out = '0;
    logic [BW-1:0]    D1_data_out = '0;
    logic             D0_rd, D1_rd;
    logic             out_ready;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             out_src;
    logic [CNT_W-1:0] D0_count, D1_count;
    logic             idle;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [BW:0]   sb[$];
    logic [CNT_W-1:0] exp_c0 = '0;
    logic [CNT_W-1:0] exp_c1 = '0;
    int n_cmp = 0;
    int n_fail = 0;
    int rd1_pulses = 0;
    logic prev_rd0 = 1'b0;
    logic prev_rd1 = 1'b0;

    egress_reader #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src),
        .D0_count(D0_count), .D1_count(D1_count), .idle(idle)
    );

    always #5 clk = ~clk;

    assign D0_empty = (q0.size() == 0);
    assign D1_empty = (q1.size() == 0);

    // FIFO read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (D0_rd && q0.size() > 0) D0_data_out <= q0.pop_front();
        if (D1_rd && q1.size() > 0) D1_data_out <= q1.pop_front();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {25'd0, out_src, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [BW:0] e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[BW-1:0]));
                    chk("out_src", 32'(out_src), 32'(e[BW]));
                    if (e[BW]) exp_c1 = exp_c1 + 1'b1;
                    else       exp_c0 = exp_c0 + 1'b1;
                end
            end
            if (D0_rd) begin
                chk("rd0_nonempty", 32'(D0_empty), 32'd0);
                chk("rd0_width", 32'(prev_rd0), 32'd0);
            end
            if (D1_rd) begin
                chk("rd1_nonempty", 32'(D1_empty), 32'd0);
                chk("rd1_width", 32'(prev_rd1), 32'd0);
                rd1_pulses++;
            end
        end
        prev_rd0 = D0_rd;
        prev_rd1 = D1_rd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        exp_c0 = '0;
        exp_c1 = '0;
    endtask

    task automatic wait_valid(input int max);
        int k;
        k = 0;
        while (!out_valid && k < max) begin
            step();
            k++;
        end
        if (k >= max) chk("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid || !idle) && k < max) begin
            step();
            k++;
        end
        if (k >= max) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_d0_count", 32'(D0_count), 32'd0);
        chk("rst_d1_count", 32'(D1_count), 32'd0);
        chk("rst_rd", {30'd0, D1_rd, D0_rd}, 32'd0);
        reset = 1'b0;

        // Reset while a word is held: the word is discarded.
        q0.push_back(6'h2A);
        wait_valid(20);
        chk("hold_data_2A", 32'(out_data), 32'h2A);
        reset = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_rd", {30'd0, D1_rd, D0_rd}, 32'd0);
        step();
        reset = 1'b0;
        exp_c0 = '0;
        exp_c1 = '0;
        step();
        chk("midrst_counts", {D1_count, D0_count}, 32'd0);
        chk("midrst_stay_idle", 32'(idle), 32'd1);

        // Single word from D0.
        out_ready = 1'b1;
        q0.push_back(6'h15);
        sb.push_back({1'b0, 6'h15});
        wait_drain(40);
        chk("single_d0_count", 32'(D0_count), 32'd1);
        chk("single_d1_count", 32'(D1_count), 32'd0);
        chk("single_idle", 32'(idle), 32'd1);

        // Backpressure on a D1 word.
        out_ready = 1'b0;
        rd1_pulses = 0;
        q1.push_back(6'h3C);
        sb.push_back({1'b1, 6'h3C});
        wait_valid(20);
        repeat (4) begin
            step();
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_data_stable", 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        step();
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        wait_drain(20);
        chk("bp_rd1_pulses", 32'(rd1_pulses), 32'd1);
        chk("bp_d1_count", 32'(D1_count), 32'd1);
        chk("bp_d1_count_model", 32'(D1_count), 32'(exp_c1));

        // Arbitration with both destinations loaded.
        do_reset(1);
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03);
        q1.push_back(6'h11); q1.push_back(6'h12); q1.push_back(6'h13);
`ifdef EGRESS_READER_RR_EN
        sb.push_back({1'b0, 6'h01}); sb.push_back({1'b1, 6'h11});
        sb.push_back({1'b0, 6'h02}); sb.push_back({1'b1, 6'h12});
        sb.push_back({1'b0, 6'h03}); sb.push_back({1'b1, 6'h13});
`else
        sb.push_back({1'b0, 6'h01}); sb.push_back({1'b0, 6'h02});
        sb.push_back({1'b0, 6'h03}); sb.push_back({1'b1, 6'h11});
        sb.push_back({1'b1, 6'h12}); sb.push_back({1'b1, 6'h13});
`endif
        wait_drain(100);
        chk("arb_d0_count", 32'(D0_count), 32'd3);
        chk("arb_d1_count", 32'(D1_count), 32'd3);

        // Counter wrap after 33 D0 words.
        do_reset(1);
        for (int i = 0; i < 33; i++) begin
            logic [BW-1:0] w;
            w = 6'(i * 7 + 1);
            q0.push_back(w);
            sb.push_back({1'b0, w});
        end
        wait_drain(400);
        chk("wrap_d0_count", 32'(D0_count), 32'd1);
        chk("wrap_d1_count", 32'(D1_count), 32'd0);
        chk("wrap_d0_model", 32'(D0_count), 32'(exp_c0));
        chk("wrap_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
